vending_machine_param: RTL and testbench

Parametrised vending controller, the successor to the fixed two-bit-select vending machine. It supports a configurable item count, per-item prices, multi-denomination coin input, per-item stock tracking, cancel/refund, an inactivity timeout and change return. It sits between the coin/keypad front-end and the dispenser and display drivers. All outputs are registered.

---
 rtl/vending_machine_param.sv | 212 +++++++++++++++++++++
 tb/tb_vending_machine_param.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_param.sv
// Parametrised vending controller: item select, multi-denomination coins, per-item
// stock, cancel/refund, inactivity timeout and change return. All outputs registered.
module vending_machine_param #(
  parameter int                         NUM_ITEMS   = 4,
  parameter int                         SEL_W       = 2,
  parameter int                         PRICE_W     = 8,
  parameter logic [NUM_ITEMS*PRICE_W-1:0] PRICE_LIST = {8'd100, 8'd75, 8'd50, 8'd25},
  parameter int                         STOCK_W     = 4,
  parameter int                         INIT_STOCK  = 2,
  parameter int                         TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sel_valid,
  input  logic [SEL_W-1:0]   item_sel,
  input  logic               coin_valid,
  input  logic [1:0]         coin_type,
  input  logic               vend_req,
  input  logic               cancel,
  input  logic               restock,
  output logic [PRICE_W-1:0] credit,
  output logic               dispense_valid,
  output logic [SEL_W-1:0]   dispense_item,
  output logic               change_valid,
  output logic [PRICE_W-1:0] change_amt,
  output logic               sold_out,
  output logic               coin_reject,
  output logic               busy
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  // Handshake: every input strobe is a single-cycle request sampled on the rising
  // edge; there is no back-pressure, so a request that cannot be honoured is
  // answered with a one-cycle sold_out / coin_reject pulse or silently dropped.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SELECTED = 2'd1,
    S_DISPENSE = 2'd2,
    S_CHANGE   = 2'd3
  } state_t;

  state_t                             state_q, state_d;
  logic [SEL_W-1:0]                   item_q, item_d;
  logic [TMO_W-1:0]                   tmo_q, tmo_d;
  logic [NUM_ITEMS-1:0][STOCK_W-1:0]  stock_q, stock_d;
  logic [PRICE_W-1:0]                 credit_q, credit_d;
  logic                               dispense_valid_q, dispense_valid_d;
  logic [SEL_W-1:0]                   dispense_item_q, dispense_item_d;
  logic                               change_valid_q, change_valid_d;
  logic [PRICE_W-1:0]                 change_amt_q, change_amt_d;
  logic                               sold_out_q, sold_out_d;
  logic                               coin_reject_q, coin_reject_d;
  logic                               busy_q, busy_d;

  logic [PRICE_W-1:0]                 coin_value;
  logic [PRICE_W:0]                   coin_sum;
  logic [PRICE_W-1:0]                 price_sel;
  logic [PRICE_W-1:0]                 change_calc;
  logic [STOCK_W-1:0]                 sel_stock;
  logic                               sel_in_range;
  logic                               timeout;

  always_comb begin
    case (coin_type)
      2'b00:   coin_value = PRICE_W'(5);
      2'b01:   coin_value = PRICE_W'(10);
      2'b10:   coin_value = PRICE_W'(25);
      default: coin_value = PRICE_W'(50);
    endcase
  end

  // One extra bit catches a sum that would wrap the credit register.
  assign coin_sum    = {1'b0, credit_q} + {1'b0, coin_value};
  assign change_calc = credit_q - price_sel;
  assign timeout     = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  // Decoded lookups; indices at or above NUM_ITEMS fall out as "not in range".
  always_comb begin
    price_sel    = '0;
    sel_stock    = '0;
    sel_in_range = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (item_q == SEL_W'(i)) price_sel = PRICE_LIST[i*PRICE_W +: PRICE_W];
      if (item_sel == SEL_W'(i)) begin
        sel_stock    = stock_q[i];
        sel_in_range = 1'b1;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    item_d           = item_q;
    tmo_d            = tmo_q;
    stock_d          = stock_q;
    credit_d         = credit_q;
    dispense_valid_d = 1'b0;
    dispense_item_d  = '0;
    change_valid_d   = 1'b0;
    change_amt_d     = '0;
    sold_out_d       = 1'b0;
    coin_reject_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        credit_d      = '0;
        tmo_d         = '0;
        coin_reject_d = coin_valid;
        if (restock) stock_d = {NUM_ITEMS{STOCK_W'(INIT_STOCK)}};
        if (sel_valid) begin
          if (sel_in_range && (sel_stock != '0)) begin
            item_d  = item_sel;
            state_d = S_SELECTED;
          end else begin
            sold_out_d = 1'b1;
          end
        end
      end

      S_SELECTED: begin
        if (cancel || timeout) begin
          tmo_d         = '0;
          coin_reject_d = coin_valid;
          if (credit_q != '0) begin
            state_d        = S_CHANGE;
            change_valid_d = 1'b1;
            change_amt_d   = credit_q;
          end else begin
            state_d = S_IDLE;
          end
        end else if (vend_req && (credit_q >= price_sel)) begin
          state_d          = S_DISPENSE;
          dispense_valid_d = 1'b1;
          dispense_item_d  = item_q;
          coin_reject_d    = coin_valid;
        end else if (coin_valid && !coin_sum[PRICE_W]) begin
          credit_d = coin_sum[PRICE_W-1:0];
          tmo_d    = '0;
        end else begin
          coin_reject_d = coin_valid;
          tmo_d         = tmo_q + 1'b1;
        end
      end

      S_DISPENSE: begin
        coin_reject_d = coin_valid;
        for (int i = 0; i < NUM_ITEMS; i++) begin
          if ((item_q == SEL_W'(i)) && (stock_q[i] != '0)) stock_d[i] = stock_q[i] - 1'b1;
        end
        // Credit holds the remainder while the change is on its way out.
        if (change_calc != '0) begin
          state_d        = S_CHANGE;
          change_valid_d = 1'b1;
          change_amt_d   = change_calc;
          credit_d       = change_calc;
        end else begin
          state_d  = S_IDLE;
          credit_d = '0;
        end
      end

      default: begin
        coin_reject_d = coin_valid;
        credit_d      = '0;
        state_d       = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= S_IDLE;
      item_q           <= '0;
      tmo_q            <= '0;
      stock_q          <= {NUM_ITEMS{STOCK_W'(INIT_STOCK)}};
      credit_q         <= '0;
      dispense_valid_q <= 1'b0;
      dispense_item_q  <= '0;
      change_valid_q   <= 1'b0;
      change_amt_q     <= '0;
      sold_out_q       <= 1'b0;
      coin_reject_q    <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      item_q           <= item_d;
      tmo_q            <= tmo_d;
      stock_q          <= stock_d;
      credit_q         <= credit_d;
      dispense_valid_q <= dispense_valid_d;
      dispense_item_q  <= dispense_item_d;
      change_valid_q   <= change_valid_d;
      change_amt_q     <= change_amt_d;
      sold_out_q       <= sold_out_d;
      coin_reject_q    <= coin_reject_d;
      busy_q           <= busy_d;
    end
  end

  assign credit         = credit_q;
  assign dispense_valid = dispense_valid_q;
  assign dispense_item  = dispense_item_q;
  assign change_valid   = change_valid_q;
  assign change_amt     = change_amt_q;
  assign sold_out       = sold_out_q;
  assign coin_reject    = coin_reject_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed bench for vending_machine_param: default parameters (prices 25/50/75/100,
// stock 2 per item, 64-cycle timeout). Outputs are sampled 1 ns after each rising edge.
module tb_vending_machine_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel_valid, coin_valid, vend_req, cancel, restock;
  logic [1:0] item_sel, coin_type;
  logic [7:0] credit, change_amt;
  logic [1:0] dispense_item;
  logic       dispense_valid, change_valid, sold_out, coin_reject, busy;

  int errors = 0;
  int checks = 0;

  vending_machine_param dut (
    .clk(clk), .rst(rst), .sel_valid(sel_valid), .item_sel(item_sel),
    .coin_valid(coin_valid), .coin_type(coin_type), .vend_req(vend_req),
    .cancel(cancel), .restock(restock), .credit(credit),
    .dispense_valid(dispense_valid), .dispense_item(dispense_item),
    .change_valid(change_valid), .change_amt(change_amt), .sold_out(sold_out),
    .coin_reject(coin_reject), .busy(busy)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: each applies a one-cycle strobe and returns 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_sel(input logic [1:0] it);
    sel_valid = 1'b1; item_sel = it;
    tick();
    sel_valid = 1'b0; item_sel = 2'd0;
  endtask

  task automatic do_coin(input logic [1:0] ct);
    coin_valid = 1'b1; coin_type = ct;
    tick();
    coin_valid = 1'b0; coin_type = 2'd0;
  endtask

  task automatic do_vend();
    vend_req = 1'b1;
    tick();
    vend_req = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    sel_valid = 0; coin_valid = 0; vend_req = 0; cancel = 0; restock = 0;
    item_sel = 0; coin_type = 0;
    #12;
    checks++;
    if ({credit, change_amt, dispense_item, dispense_valid, change_valid, sold_out, coin_reject, busy} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs: got credit=%0d chg=%0d item=%0d dv=%0b cv=%0b so=%0b cr=%0b busy=%0b required all 0",
               credit, change_amt, dispense_item, dispense_valid, change_valid, sold_out, coin_reject, busy);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || credit !== 8'd0) begin
      errors++; $display("FAIL reset_release: got busy=%0b credit=%0d required 0 0", busy, credit);
    end
  endtask

  task automatic test_exact_vend();
    do_sel(2'd1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL exact_sel_busy: got %0b required 1", busy); end
    do_coin(2'd2);
    checks++;
    if (credit !== 8'd25) begin errors++; $display("FAIL exact_credit25: got %0d required 25", credit); end
    do_coin(2'd2);
    checks++;
    if (credit !== 8'd50) begin errors++; $display("FAIL exact_credit50: got %0d required 50", credit); end
    do_vend();
    checks++;
    if (dispense_valid !== 1'b1 || dispense_item !== 2'd1 || change_valid !== 1'b0) begin
      errors++; $display("FAIL exact_dispense: got dv=%0b item=%0d cv=%0b required 1 1 0", dispense_valid, dispense_item, change_valid);
    end
    tick();
    checks++;
    if (dispense_valid !== 1'b0 || change_valid !== 1'b0 || busy !== 1'b0 || credit !== 8'd0) begin
      errors++; $display("FAIL exact_idle: got dv=%0b cv=%0b busy=%0b credit=%0d required 0 0 0 0", dispense_valid, change_valid, busy, credit);
    end
  endtask

  task automatic test_vend_change();
    do_sel(2'd3);
    do_coin(2'd3);
    do_coin(2'd3);
    do_coin(2'd2);
    checks++;
    if (credit !== 8'd125) begin errors++; $display("FAIL change_credit125: got %0d required 125", credit); end
    do_vend();
    checks++;
    if (dispense_valid !== 1'b1 || dispense_item !== 2'd3 || change_valid !== 1'b0) begin
      errors++; $display("FAIL change_dispense: got dv=%0b item=%0d cv=%0b required 1 3 0", dispense_valid, dispense_item, change_valid);
    end
    tick();
    checks++;
    if (change_valid !== 1'b1 || change_amt !== 8'd25 || dispense_valid !== 1'b0) begin
      errors++; $display("FAIL change_pulse: got cv=%0b amt=%0d dv=%0b required 1 25 0", change_valid, change_amt, dispense_valid);
    end
    tick();
    checks++;
    if (change_valid !== 1'b0 || change_amt !== 8'd0 || credit !== 8'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL change_done: got cv=%0b amt=%0d credit=%0d busy=%0b required 0 0 0 0", change_valid, change_amt, credit, busy);
    end
  endtask

  task automatic test_cancel();
    do_sel(2'd0);
    do_coin(2'd1);
    checks++;
    if (credit !== 8'd10) begin errors++; $display("FAIL cancel_credit10: got %0d required 10", credit); end
    do_vend();
    checks++;
    if (dispense_valid !== 1'b0 || busy !== 1'b1 || credit !== 8'd10) begin
      errors++; $display("FAIL cancel_short_vend: got dv=%0b busy=%0b credit=%0d required 0 1 10", dispense_valid, busy, credit);
    end
    do_cancel();
    checks++;
    if (change_valid !== 1'b1 || change_amt !== 8'd10) begin
      errors++; $display("FAIL cancel_refund: got cv=%0b amt=%0d required 1 10", change_valid, change_amt);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || change_valid !== 1'b0) begin
      errors++; $display("FAIL cancel_idle: got busy=%0b cv=%0b required 0 0", busy, change_valid);
    end
  endtask

  task automatic test_sold_out_restock();
    for (int n = 0; n < 2; n++) begin
      do_sel(2'd2);
      do_coin(2'd3);
      do_coin(2'd2);
      do_vend();
      checks++;
      if (dispense_valid !== 1'b1 || dispense_item !== 2'd2) begin
        errors++; $display("FAIL stock_buy%0d: got dv=%0b item=%0d required 1 2", n, dispense_valid, dispense_item);
      end
      tick();
    end
    do_sel(2'd2);
    checks++;
    if (sold_out !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL stock_sold_out: got so=%0b busy=%0b required 1 0", sold_out, busy);
    end
    tick();
    checks++;
    if (sold_out !== 1'b0) begin errors++; $display("FAIL stock_sold_out_width: got %0b required 0", sold_out); end
    restock = 1'b1;
    tick();
    restock = 1'b0;
    do_sel(2'd2);
    checks++;
    if (busy !== 1'b1 || sold_out !== 1'b0) begin
      errors++; $display("FAIL stock_after_restock: got busy=%0b so=%0b required 1 0", busy, sold_out);
    end
    do_cancel();
    checks++;
    if (busy !== 1'b0 || change_valid !== 1'b0) begin
      errors++; $display("FAIL stock_zero_cancel: got busy=%0b cv=%0b required 0 0", busy, change_valid);
    end
  endtask

  task automatic test_timeout();
    int seen;
    seen = 0;
    do_sel(2'd0);
    do_coin(2'd0);
    checks++;
    if (credit !== 8'd5) begin errors++; $display("FAIL timeout_credit5: got %0d required 5", credit); end
    for (int n = 1; n <= 80; n++) begin
      tick();
      if (change_valid === 1'b1) begin
        seen = n;
        break;
      end
    end
    checks++;
    if (seen !== 64 || change_amt !== 8'd5) begin
      errors++; $display("FAIL timeout_refund: got cycle=%0d amt=%0d required cycle=64 amt=5", seen, change_amt);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: got busy=%0b required 0", busy); end
    do_coin(2'd3);
    checks++;
    if (coin_reject !== 1'b1 || credit !== 8'd0) begin
      errors++; $display("FAIL idle_coin_reject: got cr=%0b credit=%0d required 1 0", coin_reject, credit);
    end
    tick();
    checks++;
    if (coin_reject !== 1'b0) begin errors++; $display("FAIL idle_coin_reject_width: got %0b required 0", coin_reject); end
  endtask

  task automatic test_overflow();
    do_sel(2'd3);
    for (int n = 0; n < 5; n++) do_coin(2'd3);
    checks++;
    if (credit !== 8'd250) begin errors++; $display("FAIL overflow_credit250: got %0d required 250", credit); end
    do_coin(2'd1);
    checks++;
    if (coin_reject !== 1'b1 || credit !== 8'd250) begin
      errors++; $display("FAIL overflow_reject: got cr=%0b credit=%0d required 1 250", coin_reject, credit);
    end
    do_coin(2'd0);
    checks++;
    if (coin_reject !== 1'b0 || credit !== 8'd255) begin
      errors++; $display("FAIL overflow_fill255: got cr=%0b credit=%0d required 0 255", coin_reject, credit);
    end
    do_cancel();
    checks++;
    if (change_valid !== 1'b1 || change_amt !== 8'd255) begin
      errors++; $display("FAIL overflow_refund: got cv=%0b amt=%0d required 1 255", change_valid, change_amt);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_sel(2'd3);
    do_coin(2'd3);
    do_coin(2'd3);
    vend_req = 1'b1; coin_valid = 1'b1; coin_type = 2'd0;
    tick();
    vend_req = 1'b0; coin_valid = 1'b0;
    checks++;
    if (dispense_valid !== 1'b1 || dispense_item !== 2'd3 || coin_reject !== 1'b1) begin
      errors++; $display("FAIL b2b_vend_coin: got dv=%0b item=%0d cr=%0b required 1 3 1", dispense_valid, dispense_item, coin_reject);
    end
    tick();
    checks++;
    if (change_valid !== 1'b0 || busy !== 1'b0 || credit !== 8'd0) begin
      errors++; $display("FAIL b2b_no_change: got cv=%0b busy=%0b credit=%0d required 0 0 0", change_valid, busy, credit);
    end
    do_sel(2'd1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_reselect: got busy=%0b required 1", busy); end
  endtask

  task automatic test_async_reset();
    do_coin(2'd3);
    checks++;
    if (credit !== 8'd50 || busy !== 1'b1) begin
      errors++; $display("FAIL areset_pre: got credit=%0d busy=%0b required 50 1", credit, busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (credit !== 8'd0 || busy !== 1'b0 || change_valid !== 1'b0 || dispense_valid !== 1'b0) begin
      errors++; $display("FAIL areset_immediate: got credit=%0d busy=%0b cv=%0b dv=%0b required 0 0 0 0", credit, busy, change_valid, dispense_valid);
    end
    #1 rst = 1'b1;
    tick();
    checks++;
    if (credit !== 8'd0 || busy !== 1'b0 || change_valid !== 1'b0) begin
      errors++; $display("FAIL areset_after: got credit=%0d busy=%0b cv=%0b required 0 0 0", credit, busy, change_valid);
    end
  endtask

  initial begin
    test_reset();
    test_exact_vend();
    test_vend_change();
    test_cancel();
    test_sold_out_restock();
    test_timeout();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
